// File: rtl/viterbi_out_ctrl_pkg.sv
// Shared constants for the Viterbi decoder output controller.
// FSM encodings and survivor-mux geometry.
package viterbi_defs;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int NUM_STATES = 4;
  localparam int SEL_W      = 2;
  localparam int DEF_PM_W   = 3;

endpackage

// File: rtl/viterbi_out_ctrl_min2.sv
// Two-way (index, metric) compare; the "a" side is the lower
// index and wins ties.
module min2_idx
  import viterbi_defs::*;
#(
  parameter int PM_W = DEF_PM_W
) (
  input  logic [SEL_W-1:0] idx_a_i,
  input  logic [PM_W-1:0]  pm_a_i,
  input  logic [SEL_W-1:0] idx_b_i,
  input  logic [PM_W-1:0]  pm_b_i,
  output logic [SEL_W-1:0] idx_o,
  output logic [PM_W-1:0]  pm_o
);

  logic a_wins;

  assign a_wins = (pm_a_i <= pm_b_i);
  assign idx_o  = a_wins ? idx_a_i : idx_b_i;
  assign pm_o   = a_wins ? pm_a_i : pm_b_i;

endmodule

// File: rtl/viterbi_out_ctrl.sv
// Per-symbol survivor-mux select: 2-stage min-metric tournament,
// frame sequencing and metric-normalisation request.
module viterbi_out_ctrl
  import viterbi_defs::*;
#(
  parameter int PM_W      = DEF_PM_W,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8,
  parameter int NORM_TH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pm_valid,
  input  logic [PM_W-1:0]  pm0,
  input  logic [PM_W-1:0]  pm1,
  input  logic [PM_W-1:0]  pm2,
  input  logic [PM_W-1:0]  pm3,
  output logic [SEL_W-1:0] control,
  output logic             ctrl_valid,
  output logic             norm_en,
  output logic [PM_W-1:0]  norm_val,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sym_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [PM_W:0]    TH   = (PM_W + 1)'(NORM_TH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             done_q, done_d;
  logic             accept;

  logic             s1_v_q;
  logic [SEL_W-1:0] s1_ia_q, s1_ib_q;
  logic [PM_W-1:0]  s1_pa_q, s1_pb_q;
  logic [SEL_W-1:0] w01_idx, w23_idx, fin_idx;
  logic [PM_W-1:0]  w01_pm, w23_pm, fin_pm;

  logic             cv_q, ne_q;
  logic [SEL_W-1:0] ctrl_q;
  logic [PM_W-1:0]  nval_q;

  assign accept = (state_q == RUN) && pm_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (pm_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = FLUSH;
            flush_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        // done leaves FLUSH together with the return to IDLE
        if (flush_q) begin
          flush_d = 1'b0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  min2_idx #(.PM_W(PM_W)) u_m01 (
    .idx_a_i(2'd0), .pm_a_i(pm0),
    .idx_b_i(2'd1), .pm_b_i(pm1),
    .idx_o(w01_idx), .pm_o(w01_pm)
  );

  min2_idx #(.PM_W(PM_W)) u_m23 (
    .idx_a_i(2'd2), .pm_a_i(pm2),
    .idx_b_i(2'd3), .pm_b_i(pm3),
    .idx_o(w23_idx), .pm_o(w23_pm)
  );

  min2_idx #(.PM_W(PM_W)) u_fin (
    .idx_a_i(s1_ia_q), .pm_a_i(s1_pa_q),
    .idx_b_i(s1_ib_q), .pm_b_i(s1_pb_q),
    .idx_o(fin_idx), .pm_o(fin_pm)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q  <= 1'b0;
      s1_ia_q <= '0;
      s1_pa_q <= '0;
      s1_ib_q <= '0;
      s1_pb_q <= '0;
      cv_q    <= 1'b0;
      ne_q    <= 1'b0;
      ctrl_q  <= '0;
      nval_q  <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_ia_q <= w01_idx;
        s1_pa_q <= w01_pm;
        s1_ib_q <= w23_idx;
        s1_pb_q <= w23_pm;
      end
      cv_q <= s1_v_q;
      ne_q <= s1_v_q && ({1'b0, fin_pm} >= TH);
      if (s1_v_q) begin
        ctrl_q <= fin_idx;
        nval_q <= fin_pm;
      end
    end
  end

  assign control    = ctrl_q;
  assign ctrl_valid = cv_q;
  assign norm_en    = ne_q;
  assign norm_val   = nval_q;
  assign busy       = (state_q == RUN) || (state_q == FLUSH);
  assign done       = done_q;
  assign sym_cnt    = cnt_q;

endmodule

// File: tb/tb_viterbi_out_ctrl.sv
// Directed and random checks of viterbi_out_ctrl with an
// argmin scoreboard consumed on every ctrl_valid.
module tb_viterbi_out_ctrl;

  localparam int PM_W      = 3;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 8;
  localparam int NORM_TH   = 4;

  logic             clk = 1'b0;
  logic             reset, start, pm_valid;
  logic [PM_W-1:0]  pm0, pm1, pm2, pm3;
  logic [1:0]       control;
  logic             ctrl_valid, norm_en, busy, done;
  logic [PM_W-1:0]  norm_val;
  logic [CNT_W-1:0] sym_cnt;

  typedef struct {
    logic [1:0]      idx;
    logic [PM_W-1:0] val;
    logic            ne;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cv_cnt = 0;
  int   n_rand = 0;
  int   cv0;

  viterbi_out_ctrl #(
    .PM_W(PM_W), .FRAME_LEN(FRAME_LEN),
    .CNT_W(CNT_W), .NORM_TH(NORM_TH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pm_valid(pm_valid),
    .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
    .control(control), .ctrl_valid(ctrl_valid),
    .norm_en(norm_en), .norm_val(norm_val),
    .busy(busy), .done(done), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t ref_min(input logic [PM_W-1:0] a, b, c, d);
    logic [PM_W-1:0] v[4];
    exp_t e;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    e.idx = 2'd0;
    e.val = a;
    for (int i = 1; i < 4; i++)
      if (v[i] < e.val) begin
        e.val = v[i];
        e.idx = 2'(i);
      end
    e.ne = (int'(e.val) >= NORM_TH);
    return e;
  endfunction

  task automatic send(input logic [PM_W-1:0] a, b, c, d);
    pm0 = a; pm1 = b; pm2 = c; pm3 = d;
    pm_valid = 1'b1;
    exp_q.push_back(ref_min(a, b, c, d));
    tick();
    pm_valid = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_control"}, control, 0);
    chk({tag, "_ctrl_valid"}, ctrl_valid, 0);
    chk({tag, "_norm_en"}, norm_en, 0);
    chk({tag, "_norm_val"}, norm_val, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sym_cnt"}, sym_cnt, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    pm_valid = 1'b0;
    exp_q.delete();
    tick();
    tick();
    chk_zero("rst");
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 6 && !done; k++) tick();
    chk({tag, "_done_seen"}, done, 1);
  endtask

  always @(negedge clk) begin
    if (!reset && ctrl_valid) begin
      exp_t e;
      cv_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_ctrl_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("mon_control", control, e.idx);
        chk("mon_norm_val", norm_val, e.val);
        chk("mon_norm_en", norm_en, e.ne);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0;
    do_reset();

    // single symbol, then ties, within one frame
    start_frame();
    chk("run_busy", busy, 1);
    chk("run_cnt0", sym_cnt, 0);
    send(3'd5, 3'd2, 3'd7, 3'd3);
    chk("single_cv_early", ctrl_valid, 0);
    chk("single_cnt", sym_cnt, 1);
    tick();
    chk("single_cv", ctrl_valid, 1);
    chk("single_control", control, 1);
    chk("single_norm_val", norm_val, 2);
    chk("single_norm_en", norm_en, 0);
    tick();
    chk("hold_cv", ctrl_valid, 0);
    chk("hold_control", control, 1);
    chk("hold_norm_val", norm_val, 2);
    send(3'd4, 3'd4, 3'd4, 3'd4);
    tick();
    chk("tie4_control", control, 0);
    chk("tie4_norm_en", norm_en, 1);
    chk("tie4_norm_val", norm_val, 4);
    send(3'd6, 3'd3, 3'd3, 3'd5);
    tick();
    chk("tie33_control", control, 1);
    chk("tie33_norm_en", norm_en, 0);

    // reset while a symbol sits in S1
    send(3'd1, 3'd0, 3'd2, 3'd3);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk_zero("async_rst");
    cv0 = cv_cnt;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("rst_no_cv", cv_cnt, cv0);
    chk("rst_no_done", done, 0);
    chk("rst_idle", busy, 0);

    // full frame, back-to-back symbols
    start_frame();
    cv0 = cv_cnt;
    for (int i = 0; i < FRAME_LEN; i++)
      send(3'((i * 3) % 8), 3'((i * 5 + 1) % 8),
           3'((7 - i) % 8), 3'((i + 4) % 8));
    chk("ff_busy_flush", busy, 1);
    chk("ff_cnt", sym_cnt, FRAME_LEN);
    pm_valid = 1'b1;
    tick();
    chk("ff_last_cv", ctrl_valid, 1);
    chk("ff_done_early", done, 0);
    tick();
    pm_valid = 1'b0;
    chk("ff_done", done, 1);
    chk("ff_busy_done", busy, 0);
    chk("ff_cv_after", ctrl_valid, 0);
    chk("ff_cv_count", cv_cnt - cv0, FRAME_LEN);
    pm_valid = 1'b1;
    tick();
    chk("ff_done_pulse", done, 0);
    tick();
    tick();
    pm_valid = 1'b0;
    tick();
    chk("idle_no_cv", cv_cnt - cv0, FRAME_LEN);
    chk("idle_cnt_hold", sym_cnt, FRAME_LEN);

    // bubbles, start during RUN, start in done cycle
    do_reset();
    pm_valid = 1'b1;
    start_frame();
    chk("start_cycle_ignored", sym_cnt, 0);
    send(3'd7, 3'd6, 3'd5, 3'd4);
    tick();
    chk("bub_cv1", ctrl_valid, 1);
    chk("bub_ctl1", control, 3);
    send(3'd0, 3'd1, 3'd1, 3'd0);
    chk("bub_cv_gap", ctrl_valid, 0);
    tick();
    chk("bub_cv2", ctrl_valid, 1);
    chk("bub_ctl2", control, 0);
    chk("bub_cnt", sym_cnt, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_cnt", sym_cnt, 2);
    chk("run_start_busy", busy, 1);
    for (int i = 2; i < FRAME_LEN; i++)
      send(3'(i % 8), 3'd7, 3'd7, 3'd7);
    wait_done("bub");
    start_frame();
    chk("b2b_cnt", sym_cnt, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_done_off", done, 0);

    // random frames with bubbles, each started in the done cycle
    do_reset();
    start_frame();
    while (n_rand < 1000) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        if ($urandom_range(3) == 0) tick();
        send(3'($urandom_range(7)), 3'($urandom_range(7)),
             3'($urandom_range(7)), 3'($urandom_range(7)));
        n_rand++;
      end
      wait_done("rand");
      chk("rand_cnt", sym_cnt, FRAME_LEN);
      start_frame();
    end
    for (int k = 0; k < 4; k++) tick();
    chk("pending_ctrl", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
